// File: rtl/joybus_pkg.sv
// rtl/joybus_pkg.sv - shared state encoding, register map and status bit positions
package joybus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_BIT,
        ST_TX_STOP,
        ST_RX_WAIT,
        ST_RX_BIT,
        ST_RX_END
    } state_t;

    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_CTRL  = 2'd1;
    localparam logic [1:0] REG_RXLEN = 2'd2;
    localparam logic [1:0] REG_CLEAR = 2'd3;

    localparam int STAT_BUSY     = 7;
    localparam int STAT_TIMEOUT  = 6;
    localparam int STAT_OVERFLOW = 5;
    localparam int STAT_TX_EMPTY = 4;

endpackage

// File: rtl/joybus_if.sv
// rtl/joybus_if.sv - CPU register access port of one joybus channel
interface joybus_if;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic       write;
    logic       ce;
    logic [7:0] data_out;

    modport master (output addr, data_in, write, ce, input data_out);
    modport slave  (input addr, data_in, write, ce, output data_out);
endinterface

// File: rtl/joybus_fifo.sv
// rtl/joybus_fifo.sv - first-word-fall-through byte FIFO with flush
module joybus_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [7:0]             pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // a full FIFO still accepts a push when the same cycle frees a slot
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // pointers and occupancy; a flush wins over any push or pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // byte storage, not reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/joybus_channel.sv
// rtl/joybus_channel.sv - one controller-port joybus transceiver with TX/RX FIFOs
module joybus_channel
    import joybus_pkg::*;
#(
    parameter int US_CYCLES  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT_US = 100
) (
    input  logic     clk,
    input  logic     reset,
    joybus_if.slave  bus,
    input  logic     joy_in,
    output logic     joy_oe,
    output logic     done
);
    localparam int BIT_CYC  = 4 * US_CYCLES;
    localparam int STOP_CYC = 3 * US_CYCLES;
    localparam int TO_CYC   = TIMEOUT_US * US_CYCLES;
    localparam int TW       = $clog2(TO_CYC + BIT_CYC);
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;

    state_t        state;
    logic [TW-1:0] tmr;
    logic [2:0]    bit_idx;
    logic [7:0]    tx_sh, rx_byte, byte_cnt, rxlen;
    logic [6:0]    rx_sh;
    logic          rx_push, end_seen, timeout, rx_ovf;
    logic          sync1, sync2, sync_prev, fall;
    logic          wr, rd, busy, start, clear;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic          rx_pop, rx_full, rx_empty;
    logic [7:0]    tx_head, rx_head;
    logic [CW-1:0] tx_count, rx_count;
    logic          unused_tx;

    assign unused_tx = ^{tx_full, tx_count};

    assign wr      = bus.ce && bus.write;
    assign rd      = bus.ce && !bus.write;
    assign busy    = (state != ST_IDLE) || done;
    assign start   = wr && (bus.addr == REG_CTRL) && bus.data_in[0] && !busy;
    assign clear   = wr && (bus.addr == REG_CLEAR) && !busy;
    assign tx_push = wr && (bus.addr == REG_DATA);
    assign rx_pop  = rd && (bus.addr == REG_DATA);
    assign tx_pop  = !tx_empty && (start ||
                     (state == ST_TX_BIT && tmr == TW'(BIT_CYC - 1) && bit_idx == 3'd7));
    assign fall    = sync_prev && !sync2;

    joybus_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .clear(clear),
        .push(tx_push), .push_data(bus.data_in),
        .pop(tx_pop), .pop_data(tx_head),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    joybus_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .clear(clear),
        .push(rx_push), .push_data(rx_byte),
        .pop(rx_pop), .pop_data(rx_head),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // register read mux
    always_comb begin
        bus.data_out = 8'h00;
        case (bus.addr)
            REG_DATA:  bus.data_out = rx_empty ? 8'h00 : rx_head;
            REG_CTRL:  bus.data_out = {busy, timeout, rx_ovf, tx_empty, 4'(rx_count)};
            REG_RXLEN: bus.data_out = rxlen;
            default:   bus.data_out = 8'h00;
        endcase
    end

    // expected reply length register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              rxlen <= 8'h00;
        else if (wr && bus.addr == REG_RXLEN)  rxlen <= bus.data_in;
    end

    // line synchronizer plus one extra stage for falling-edge detection; idles high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {sync1, sync2, sync_prev} <= 3'b111;
        end else begin
            sync1     <= joy_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // transaction sequencer: bit timing, line drive, reply capture and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            tmr      <= '0;
            bit_idx  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_byte  <= '0;
            byte_cnt <= '0;
            rx_push  <= 1'b0;
            end_seen <= 1'b0;
            timeout  <= 1'b0;
            rx_ovf   <= 1'b0;
            joy_oe   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done    <= 1'b0;
            rx_push <= 1'b0;
            if (clear) begin
                timeout <= 1'b0;
                rx_ovf  <= 1'b0;
            end
            if (rx_push && rx_full && !rx_pop) rx_ovf <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tmr      <= '0;
                        bit_idx  <= '0;
                        byte_cnt <= '0;
                        if (!tx_empty) begin
                            state  <= ST_TX_BIT;
                            tx_sh  <= tx_head;
                            joy_oe <= 1'b1;
                        end else if (rxlen != 8'h00) begin
                            state <= ST_RX_WAIT;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_TX_BIT: begin
                    if (tmr == TW'(BIT_CYC - 1)) begin
                        tmr    <= '0;
                        joy_oe <= 1'b1;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (!tx_empty) tx_sh <= tx_head;
                            else           state <= ST_TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                        end
                    end else begin
                        tmr    <= tmr + 1'b1;
                        joy_oe <= (tmr + 1'b1) < (tx_sh[7] ? TW'(US_CYCLES) : TW'(3 * US_CYCLES));
                    end
                end
                ST_TX_STOP: begin
                    if (tmr == TW'(STOP_CYC - 1)) begin
                        tmr    <= '0;
                        joy_oe <= 1'b0;
                        if (rxlen != 8'h00) begin
                            state <= ST_RX_WAIT;
                        end else begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end else begin
                        tmr    <= tmr + 1'b1;
                        joy_oe <= (tmr + 1'b1) < TW'(US_CYCLES);
                    end
                end
                ST_RX_WAIT: begin
                    if (fall) begin
                        state <= ST_RX_BIT;
                        tmr   <= '0;
                    end else if (tmr == TW'(TO_CYC - 1)) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                        done    <= 1'b1;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                ST_RX_BIT: begin
                    if (tmr == TW'(2 * US_CYCLES - 1)) begin
                        tmr     <= '0;
                        rx_sh   <= {rx_sh[5:0], sync2};
                        bit_idx <= bit_idx + 3'd1;
                        state   <= ST_RX_WAIT;
                        if (bit_idx == 3'd7) begin
                            rx_byte  <= {rx_sh, sync2};
                            rx_push  <= 1'b1;
                            byte_cnt <= byte_cnt + 8'd1;
                            if (byte_cnt + 8'd1 == rxlen) begin
                                state    <= ST_RX_END;
                                end_seen <= 1'b0;
                            end
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                ST_RX_END: begin
                    if (!end_seen && fall) begin
                        end_seen <= 1'b1;
                        tmr      <= '0;
                    end else if (end_seen && sync2) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end else if (tmr == TW'(TO_CYC - 1)) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
